// File: rtl/wts_env_pkg.sv
// Shared constants, state encoding and rate helper for the wave table sound
// envelope generator.
package wts_env_pkg;

  localparam int WTS_ENV_W      = 5;
  localparam int WTS_ENV_MAX    = 31;
  localparam int WTS_RATE_W     = 4;
  localparam int WTS_RATE_CNT_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } wts_env_state_t;

  // Last counter value of a step period: a rate r (1..15) steps every
  // 2^(15-r) strobes, so the counter runs 0 .. 2^(15-r)-1. Rate 0 never
  // steps; its return value is irrelevant.
  function automatic logic [WTS_RATE_CNT_W-1:0] rate_last_count(
    input logic [WTS_RATE_W-1:0] rate
  );
    logic [WTS_RATE_CNT_W-1:0] all_ones;
    all_ones = '1;
    return all_ones >> (rate - 4'd1);
  endfunction

endpackage

// File: rtl/wts_env_rate_counter.sv
// Strobe-paced rate divider: emits a one-cycle step pulse, coincident with an
// active strobe, once per 2^(15-rate) strobes. Rate 0 never steps.
module wts_env_rate_counter
  import wts_env_pkg::*;
(
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  active,
  input  logic                  clear,
  input  logic [WTS_RATE_W-1:0] rate,
  output logic                  step
);

  logic [WTS_RATE_CNT_W-1:0] cnt_q, cnt_d;
  logic                      rate_on;

  // Step decision and next count; a lowered period with the count already
  // past it steps on the very next strobe because of the >= compare.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    rate_on = (rate != '0);
    step    = active && rate_on && (cnt_q >= rate_last_count(rate));
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = '0;
    end else if (active && rate_on) begin
      cnt_d = cnt_q + 14'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge nreset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wts_envelope_generator.sv
// Per-channel ADSR envelope generator paced by the sample-rate active strobe.
// Optional macro WTS_KEY_RETRIGGER_EN: when defined, a rising key edge also
// forces the level to 0 so every note attacks from silence; when undefined,
// the attack continues upward from the current level.
module wts_envelope_generator
  import wts_env_pkg::*;
(
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 active,
  input  logic                 key_on,
  input  logic [WTS_RATE_W-1:0] reg_ar,
  input  logic [WTS_RATE_W-1:0] reg_dr,
  input  logic [WTS_RATE_W-1:0] reg_sl,
  input  logic [WTS_RATE_W-1:0] reg_rr,
  output logic [WTS_ENV_W-1:0] envelope,
  output logic                 busy
);

  localparam logic [WTS_ENV_W-1:0] ENV_MAX = WTS_ENV_W'(WTS_ENV_MAX);

  wts_env_state_t       state_q, state_d;
  logic [WTS_ENV_W-1:0] env_q, env_d;
  logic                 busy_q;
  // key_sync_q is the registered key (key_d); key_prev_q is its history, so
  // the edge acts on the state one clock after it lands in key_sync_q.
  logic                 key_sync_q, key_prev_q;
  logic                 key_rise, key_fall;
  logic [WTS_ENV_W-1:0] target;
  logic [WTS_RATE_W-1:0] rate_sel;
  logic                 rate_clear;
  logic                 step;

  assign key_rise = key_sync_q & ~key_prev_q;
  assign key_fall = ~key_sync_q & key_prev_q;
  assign target   = {reg_sl, 1'b0};

  // Rate for the current phase; idle and sustain never step.
  always_comb begin
    rate_sel = '0;
    case (state_q)
      ST_ATTACK:  rate_sel = reg_ar;
      ST_DECAY:   rate_sel = reg_dr;
      ST_RELEASE: rate_sel = reg_rr;
      default:    rate_sel = '0;
    endcase
  end

  wts_env_rate_counter u_rate_counter (
    .clk    (clk),
    .nreset (nreset),
    .active (active),
    .clear  (rate_clear),
    .rate   (rate_sel),
    .step   (step)
  );

  // State, level and key history registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      env_q      <= '0;
      busy_q     <= 1'b0;
      key_sync_q <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      env_q      <= env_d;
      busy_q     <= (state_d != ST_IDLE);
      key_sync_q <= key_on;
      key_prev_q <= key_sync_q;
    end
  end

  // Next state and level; key edges pre-empt any step in the same cycle.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (key_rise) begin
      state_d = ST_ATTACK;
`ifdef WTS_KEY_RETRIGGER_EN
      env_d   = '0;
`endif
    end else if (key_fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                              state_q == ST_SUSTAIN)) begin
      state_d = ST_RELEASE;
    end else begin
      case (state_q)
        ST_ATTACK: begin
          if (active && env_q == ENV_MAX) begin
            state_d = ST_DECAY;
          end else if (step) begin
            env_d = env_q + 5'd1;
            if (env_q == ENV_MAX - 5'd1) state_d = ST_DECAY;
          end
        end
        ST_DECAY: begin
          if (active && env_q <= target) begin
            state_d = ST_SUSTAIN;
          end else if (step) begin
            env_d = env_q - 5'd1;
            if (env_q == target + 5'd1) state_d = ST_SUSTAIN;
          end
        end
        ST_RELEASE: begin
          if (active && env_q == '0) begin
            state_d = ST_IDLE;
          end else if (step) begin
            env_d = env_q - 5'd1;
            if (env_q == 5'd1) state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Any state change, including an attack retrigger, restarts the rate count.
  assign rate_clear = key_rise || (state_d != state_q);

  // Outputs come straight from registers.
  always_comb begin
    envelope = env_q;
    busy     = busy_q;
  end

endmodule

// File: tb/tb_wts_envelope_generator.sv
// Scoreboard bench for wts_envelope_generator: the stimulus pushes every
// expected change of {envelope, busy}; a monitor pops and compares whenever
// the outputs change. Spot checks confirm exact strobe pacing.
module tb_wts_envelope_generator;

  typedef struct packed {
    logic [4:0] env;
    logic       busy;
  } obs_t;

  logic       clk;
  logic       nreset;
  logic       active;
  logic       key_on;
  logic [3:0] reg_ar, reg_dr, reg_sl, reg_rr;
  logic [4:0] envelope;
  logic       busy;

  int   vectors;
  int   miscompares;
  obs_t exp_q[$];
  bit   mon_en;
  obs_t prev_obs;
  int   cur;

  wts_envelope_generator dut (
    .clk      (clk),
    .nreset   (nreset),
    .active   (active),
    .key_on   (key_on),
    .reg_ar   (reg_ar),
    .reg_dr   (reg_dr),
    .reg_sl   (reg_sl),
    .reg_rr   (reg_rr),
    .envelope (envelope),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic push(input int e, input bit b);
    obs_t o;
    o.env  = 5'(e);
    o.busy = b;
    exp_q.push_back(o);
  endtask

  // One active strobe followed by three quiet clocks.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); active = 1'b1;
      @(negedge clk); active = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every change of the outputs must match the next expected entry.
  always @(negedge clk) begin
    obs_t now_obs;
    obs_t e;
    if (mon_en) begin
      now_obs = {envelope, busy};
      if (now_obs !== prev_obs) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_change: got env=%0d busy=%0d, no change expected at %0t",
                   now_obs.env, now_obs.busy, $time);
        end else begin
          e = exp_q.pop_front();
          check("scoreboard_env_busy", 32'(now_obs), 32'(e));
        end
        prev_obs = now_obs;
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    prev_obs    = '0;
    nreset      = 1'b0;
    active      = 1'b0;
    key_on      = 1'b0;
    reg_ar      = 4'd15;
    reg_dr      = 4'd15;
    reg_sl      = 4'd8;
    reg_rr      = 4'd15;

    // Reset held for 50 clocks, outputs silent throughout and after release.
    repeat (50) begin
      @(negedge clk);
      check("reset_env", 32'(envelope), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
    end
    nreset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_env", 32'(envelope), 32'd0);
      check("post_reset_busy", 32'(busy), 32'd0);
    end
    prev_obs = '0;
    mon_en   = 1'b1;

    // Full ADSR cycle with the fastest rates, sustain target 16.
    key_on = 1'b1;
    push(0, 1'b1);
    settle();
    for (int i = 1; i <= 31; i++) push(i, 1'b1);
    for (int i = 30; i >= 16; i--) push(i, 1'b1);
    tick(49);
    check("sustain_hold", 32'(envelope), 32'd16);
    key_on = 1'b0;
    settle();
    for (int i = 15; i >= 1; i--) push(i, 1'b1);
    push(0, 1'b0);
    tick(18);
    check("release_idle_busy", 32'(busy), 32'd0);

    // Attack rate 13: exactly four strobes per increment.
    reg_ar = 4'd13;
    key_on = 1'b1;
    push(0, 1'b1);
    settle();
    for (int i = 1; i <= 3; i++) push(i, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick(3);
      check("ar13_before_step", 32'(envelope), 32'(k - 1));
      tick(1);
      check("ar13_at_step", 32'(envelope), 32'(k));
    end
    key_on = 1'b0;
    settle();
    push(2, 1'b1); push(1, 1'b1); push(0, 1'b0);
    tick(4);

    // Attack rate 0 holds the level while busy.
    reg_ar = 4'd0;
    key_on = 1'b1;
    push(0, 1'b1);
    settle();
    tick(1000);
    check("ar0_hold_env", 32'(envelope), 32'd0);
    check("ar0_hold_busy", 32'(busy), 32'd1);
    key_on = 1'b0;
    push(0, 1'b0);
    settle();
    tick(2);

    // Release during attack at level 10, release paced at four strobes.
    reg_ar = 4'd14;
    reg_rr = 4'd13;
    key_on = 1'b1;
    push(0, 1'b1);
    settle();
    for (int i = 1; i <= 10; i++) push(i, 1'b1);
    tick(20);
    check("attack_to_10", 32'(envelope), 32'd10);
    key_on = 1'b0;
    settle();
    for (int i = 9; i >= 1; i--) push(i, 1'b1);
    push(0, 1'b0);
    tick(40);
    check("release_from_attack_idle", 32'(busy), 32'd0);

    // Retrigger during release at level 12.
    reg_ar = 4'd15;
    reg_rr = 4'd15;
    key_on = 1'b1;
    push(0, 1'b1);
    settle();
    for (int i = 1; i <= 20; i++) push(i, 1'b1);
    tick(20);
    key_on = 1'b0;
    settle();
    for (int i = 19; i >= 12; i--) push(i, 1'b1);
    tick(8);
    check("release_to_12", 32'(envelope), 32'd12);
    key_on = 1'b1;
`ifdef WTS_KEY_RETRIGGER_EN
    push(0, 1'b1);
    settle();
    push(1, 1'b1); push(2, 1'b1);
    tick(2);
    check("retrigger_from_zero", 32'(envelope), 32'd2);
    cur = 2;
`else
    settle();
    push(13, 1'b1); push(14, 1'b1);
    tick(2);
    check("retrigger_from_level", 32'(envelope), 32'd14);
    cur = 14;
`endif
    key_on = 1'b0;
    settle();
    for (int i = cur - 1; i >= 1; i--) push(i, 1'b1);
    push(0, 1'b0);
    tick(cur + 1);

    // Asynchronous reset in DECAY; a key held through reset re-attacks.
    reg_dr = 4'd13;
    reg_rr = 4'd13;
    key_on = 1'b1;
    push(0, 1'b1);
    settle();
    for (int i = 1; i <= 31; i++) push(i, 1'b1);
    push(30, 1'b1);
    tick(35);
    check("decay_to_30", 32'(envelope), 32'd30);
    @(negedge clk);
    #1 nreset = 1'b0;
    #1;
    check("async_reset_env", 32'(envelope), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    push(0, 1'b0);
    push(0, 1'b1);
    repeat (3) @(negedge clk);
    #1 nreset = 1'b1;
    settle();
    for (int i = 1; i <= 31; i++) push(i, 1'b1);
    push(30, 1'b1);
    tick(35);
    check("redecay_to_30", 32'(envelope), 32'd30);

    // Falling key edge lands on the same clock as a decay step strobe.
    tick(3);
    key_on = 1'b0;
    tick(1);
    check("collision_no_step", 32'(envelope), 32'd30);
    tick(3);
    check("collision_counter_cleared", 32'(envelope), 32'd30);
    for (int i = 29; i >= 1; i--) push(i, 1'b1);
    push(0, 1'b0);
    tick(1);
    check("release_first_step", 32'(envelope), 32'd29);
    tick(116);
    check("final_idle_busy", 32'(busy), 32'd0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
